// File: rtl/ahb_apb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_apb_pkg
//
// Shared definitions for the AHB-to-APB bridge control stage.
//   - bridge_state_e : control FSM states
//   - HTRANS_*       : AHB transfer type encodings
//   - HRESP_*        : AHB response encodings
//   - is_active_trans: true for transfer types that request a real transfer
// ----------------------------------------------------------------------------
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WWAIT  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        DONE   = 3'd4,
        ERR1   = 3'd5,
        ERR2   = 3'd6
    } bridge_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // NONSEQ and SEQ are the only transfer types that move data; IDLE and
    // BUSY always receive a zero-wait OKAY without touching the APB side.
    function automatic logic is_active_trans(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage : ahb_apb_pkg

// File: rtl/apb_timeout_cnt.sv
// ----------------------------------------------------------------------------
// apb_timeout_cnt
//
// Wait-cycle counter for the APB ACCESS phase. Only instantiated by the
// bridge when APB_TIMEOUT_EN is defined.
//
// Ports:
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset
//   clear_i    : zero the count (asserted in the cycle before ACCESS starts)
//   count_en_i : add one (asserted on each ACCESS cycle with PREADY low)
//   expired_o  : current ACCESS cycle is the last one allowed
//
// Parameters:
//   TIMEOUT_CYC : number of ACCESS cycles tolerated before giving up
// ----------------------------------------------------------------------------
module apb_timeout_cnt
    import ahb_apb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The count holds the number of PREADY-low ACCESS cycles already seen,
    // so on ACCESS cycle k it reads k-1. Clear has priority so a fresh
    // transfer never inherits a stale count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expired means this is ACCESS cycle number TIMEOUT_CYC: if PREADY is
    // still low now, the bridge abandons the transfer at the next edge.
    assign expired_o = (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

endmodule : apb_timeout_cnt

// File: rtl/ahb_apb_bridge_fsm.sv
// ----------------------------------------------------------------------------
// ahb_apb_bridge_fsm
//
// Control stage of the AHB-to-APB bridge. Takes single AHB transfers that the
// address decoder has already qualified with PSEL_en and turns each one into
// an APB SETUP/ACCESS sequence, holding HREADYOUT low until the completer
// answers, then returning read data (OKAY) or a two-cycle ERROR response.
//
// Optional feature (macro APB_TIMEOUT_EN): an ACCESS phase that sees PREADY
// low for TIMEOUT_CYC cycles is abandoned and reported as an ERROR. Without
// the macro the bridge waits in ACCESS indefinitely and TIMEOUT_CYC is unused.
//
// Ports:
//   HCLK, HRESETn    : clock, synchronous active-low reset
//   HSEL, HADDR,
//   HTRANS, HWRITE,
//   HWDATA, HREADY   : AHB subordinate-side request inputs
//   PSEL_en          : decoder says the address maps to an APB completer
//   HREADYOUT, HRESP,
//   HRDATA           : AHB response outputs (HRDATA registered)
//   PADDR, PSEL,
//   PENABLE, PWRITE,
//   PWDATA           : APB requester outputs
//   PRDATA, PREADY,
//   PSLVERR          : APB completer response inputs
// ----------------------------------------------------------------------------
module ahb_apb_bridge_fsm
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic              PSEL_en,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    bridge_state_e state_q;
    bridge_state_e state_d;

    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] hrdata_q;

    logic acceptWindow;
    logic acceptXfer;
    logic captureRdata;
    logic timeoutExpired;

    // A new transfer can only be taken while the bridge is presenting
    // HREADYOUT=1, i.e. in IDLE, DONE or ERR2. DONE and ERR2 accept so that
    // back-to-back transfers run without an IDLE bubble.
    always_comb begin
        acceptWindow = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR2);
        acceptXfer   = acceptWindow && HSEL && HREADY && is_active_trans(HTRANS);
    end

`ifdef APB_TIMEOUT_EN
    logic cntClear;
    logic cntEnable;

    // SETUP always precedes ACCESS, so clearing during SETUP gives every
    // ACCESS phase a fresh count starting at zero.
    assign cntClear  = (state_q == SETUP);
    assign cntEnable = (state_q == ACCESS) && !PREADY;

    apb_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk_i      (HCLK),
        .rst_ni     (HRESETn),
        .clear_i    (cntClear),
        .count_en_i (cntEnable),
        .expired_o  (timeoutExpired)
    );
`else
    assign timeoutExpired = 1'b0;
`endif

    // Next-state and state-decoded outputs. Every bus-visible control signal
    // is a pure function of the current state, so HREADYOUT/HRESP/PSEL/PENABLE
    // change only on HCLK edges. PREADY wins over an expiring timeout because
    // it is checked first.
    always_comb begin
        state_d      = state_q;
        HREADYOUT    = 1'b1;
        HRESP        = HRESP_OKAY;
        PSEL         = 1'b0;
        PENABLE      = 1'b0;
        captureRdata = 1'b0;

        unique case (state_q)
            IDLE, DONE, ERR2: begin
                if (state_q == ERR2) begin
                    HRESP = HRESP_ERROR;
                end
                if (acceptXfer) begin
                    if (!PSEL_en) begin
                        state_d = ERR1;
                    end else if (HWRITE) begin
                        state_d = WWAIT;
                    end else begin
                        state_d = SETUP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            WWAIT: begin
                HREADYOUT = 1'b0;
                state_d   = SETUP;
            end

            SETUP: begin
                HREADYOUT = 1'b0;
                PSEL      = 1'b1;
                state_d   = ACCESS;
            end

            ACCESS: begin
                HREADYOUT = 1'b0;
                PSEL      = 1'b1;
                PENABLE   = 1'b1;
                if (PREADY) begin
                    if (PSLVERR) begin
                        state_d = ERR1;
                    end else begin
                        state_d      = DONE;
                        captureRdata = !pwrite_q;
                    end
                end else if (timeoutExpired) begin
                    state_d = ERR1;
                end
            end

            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ERR2;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Address and direction are captured on
    // accept and held untouched until the next accept, which keeps PADDR and
    // PWRITE stable across SETUP and every ACCESS cycle. Write data arrives
    // in the AHB data phase, which is the WWAIT cycle. HRDATA only moves on a
    // successful read so it keeps its last value across writes and errors.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (acceptXfer) begin
                paddr_q  <= HADDR;
                pwrite_q <= HWRITE;
            end
            if (state_q == WWAIT) begin
                pwdata_q <= HWDATA;
            end
            if (captureRdata) begin
                hrdata_q <= PRDATA;
            end
        end
    end

    assign PADDR  = paddr_q;
    assign PWRITE = pwrite_q;
    assign PWDATA = pwdata_q;
    assign HRDATA = hrdata_q;

endmodule : ahb_apb_bridge_fsm

// File: tb/tb_ahb_apb_bridge_fsm.sv
// ----------------------------------------------------------------------------
// tb_ahb_apb_bridge_fsm
//
// Self-checking bench for ahb_apb_bridge_fsm. The bench plays the AHB
// requester and the APB completer. For each transfer it predicts, from the
// transfer's attributes alone (direction, decode hit, wait count, completer
// error), the cycle at which HREADYOUT returns, the response, how many cycles
// PSEL and PENABLE are high, and the read data the bridge should hold.
// Works with or without APB_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module tb_ahb_apb_bridge_fsm;
    import ahb_apb_pkg::*;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 16;
    localparam int MAX_CYCLES  = 60;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic              PSEL_en;
    logic              HREADYOUT;
    logic              HRESP;
    logic [DATA_W-1:0] HRDATA;
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    int          vectorCount     = 0;
    int          miscompareCount = 0;
    logic [31:0] modelHrdata     = '0;

    always #5 HCLK = ~HCLK;

    ahb_apb_bridge_fsm #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .PSEL_en   (PSEL_en),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Hold reset for two edges, then check every reset value before release.
    task automatic applyReset();
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HTRANS  = HTRANS_IDLE;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        checkOutput("rstHreadyout", 32'(HREADYOUT), 32'd1);
        checkOutput("rstHresp",     32'(HRESP),     32'd0);
        checkOutput("rstPsel",      32'(PSEL),      32'd0);
        checkOutput("rstPenable",   32'(PENABLE),   32'd0);
        checkOutput("rstPwrite",    32'(PWRITE),    32'd0);
        checkOutput("rstPaddr",     PADDR,          32'd0);
        checkOutput("rstPwdata",    PWDATA,         32'd0);
        checkOutput("rstHrdata",    HRDATA,         32'd0);
        modelHrdata = '0;
        HRESETn     = 1'b1;
    endtask

    // A non-transfer (IDLE/BUSY type, unselected, or HREADY low) must get a
    // zero-wait OKAY and leave the APB side untouched.
    task automatic applyIdle(input int kind);
        HADDR   = $urandom;
        HWRITE  = 1'($urandom_range(0, 1));
        PSEL_en = 1'($urandom_range(0, 1));
        HREADY  = 1'b1;
        case (kind)
            0:       begin HSEL = 1'b1; HTRANS = HTRANS_IDLE;   end
            1:       begin HSEL = 1'b1; HTRANS = HTRANS_BUSY;   end
            2:       begin HSEL = 1'b0; HTRANS = HTRANS_NONSEQ; end
            3:       begin HSEL = 1'b0; HTRANS = HTRANS_SEQ;    end
            default: begin HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HREADY = 1'b0; end
        endcase
        @(posedge HCLK);
        #1;
        HSEL    = 1'b0;
        HTRANS  = HTRANS_IDLE;
        HREADY  = 1'b1;
        PREADY  = 1'($urandom_range(0, 1));
        PSLVERR = 1'($urandom_range(0, 1));
        @(negedge HCLK);
        checkOutput("idleHreadyout", 32'(HREADYOUT), 32'd1);
        checkOutput("idleHresp",     32'(HRESP),     32'd0);
        checkOutput("idlePsel",      32'(PSEL),      32'd0);
        checkOutput("idleHrdata",    HRDATA,         modelHrdata);
    endtask

    // One AHB transfer. The expected timeline comes from the transfer's
    // attributes: reads spend one cycle in SETUP, writes one extra cycle for
    // the data phase, then (waits+1) ACCESS cycles, plus one extra cycle when
    // the answer is the two-cycle ERROR. A decode miss errors immediately.
    task automatic applyStimulus(input bit isWrite, input bit decodeOk, input int waits,
                                 input bit slvErr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata);
        int   accessCyc;
        int   expReady;
        int   expPsel;
        int   expEn;
        int   readyCycle;
        int   pselCnt;
        int   enCnt;
        int   accessCnt;
        bit   expErr;
        bit   timedOut;
        logic prevResp;
        logic finalResp;

        timedOut  = 1'b0;
        accessCyc = waits + 1;
`ifdef APB_TIMEOUT_EN
        if (waits >= TIMEOUT_CYC) begin
            timedOut  = 1'b1;
            accessCyc = TIMEOUT_CYC;
        end
`endif
        if (!decodeOk) begin
            expErr   = 1'b1;
            expReady = 2;
            expPsel  = 0;
            expEn    = 0;
        end else begin
            expErr   = slvErr || timedOut;
            expReady = (isWrite ? 3 : 2) + accessCyc + (expErr ? 1 : 0);
            expPsel  = 1 + accessCyc;
            expEn    = accessCyc;
            if (!expErr && !isWrite) begin
                modelHrdata = rdata;
            end
        end

        HSEL    = 1'b1;
        HTRANS  = HTRANS_NONSEQ;
        HREADY  = 1'b1;
        HADDR   = addr;
        HWRITE  = isWrite;
        PSEL_en = decodeOk;

        readyCycle = -1;
        pselCnt    = 0;
        enCnt      = 0;
        accessCnt  = 0;
        prevResp   = 1'b0;
        finalResp  = 1'b0;

        for (int c = 1; c <= MAX_CYCLES; c++) begin
            @(posedge HCLK);
            #1;
            if (c == 1) begin
                HSEL    = 1'($urandom_range(0, 1));
                HTRANS  = 2'($urandom_range(0, 1));
                HADDR   = $urandom;
                HWRITE  = 1'($urandom_range(0, 1));
                PSEL_en = 1'($urandom_range(0, 1));
                HWDATA  = wdata;
            end
            if (PSEL && PENABLE) begin
                accessCnt++;
                PREADY  = (accessCnt > waits);
                PSLVERR = PREADY && slvErr;
                PRDATA  = PREADY ? rdata : $urandom;
            end else begin
                PREADY  = 1'($urandom_range(0, 1));
                PSLVERR = 1'($urandom_range(0, 1));
                PRDATA  = $urandom;
            end
            @(negedge HCLK);
            if (PSEL) begin
                pselCnt++;
                checkOutput("paddr", PADDR, addr);
                checkOutput("pwrite", 32'(PWRITE), 32'(isWrite));
                if (isWrite) begin
                    checkOutput("pwdata", PWDATA, wdata);
                end
            end
            if (PENABLE) begin
                enCnt++;
            end
            if (HREADYOUT) begin
                readyCycle = c;
                finalResp  = HRESP;
                break;
            end
            prevResp = HRESP;
        end

        checkOutput("latency",       readyCycle,      expReady);
        checkOutput("hrespFinal",    32'(finalResp),  32'(expErr));
        checkOutput("hrespStall",    32'(prevResp),   32'(expErr));
        checkOutput("pselCycles",    pselCnt,         expPsel);
        checkOutput("penableCycles", enCnt,           expEn);
        checkOutput("hrdata",        HRDATA,          modelHrdata);
    endtask

    // Reset asserted for one cycle in the middle of a stalled ACCESS phase:
    // the APB transfer must vanish and everything returns to reset values.
    task automatic applyResetMidAccess();
        bit seen;
        seen    = 1'b0;
        HSEL    = 1'b1;
        HTRANS  = HTRANS_NONSEQ;
        HREADY  = 1'b1;
        HADDR   = 32'h4000_0040;
        HWRITE  = 1'b0;
        PSEL_en = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge HCLK);
            #1;
            if (c == 1) begin
                HSEL   = 1'b0;
                HTRANS = HTRANS_IDLE;
            end
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            @(negedge HCLK);
            if (PSEL && PENABLE) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("midRstAccessSeen", 32'(seen), 32'd1);
        HRESETn = 1'b0;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        modelHrdata = '0;
        checkOutput("midRstPsel",      32'(PSEL),      32'd0);
        checkOutput("midRstPenable",   32'(PENABLE),   32'd0);
        checkOutput("midRstHreadyout", 32'(HREADYOUT), 32'd1);
        checkOutput("midRstHresp",     32'(HRESP),     32'd0);
        checkOutput("midRstPaddr",     PADDR,          32'd0);
        checkOutput("midRstHrdata",    HRDATA,         modelHrdata);
    endtask

    initial begin
        int op;
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HADDR   = '0;
        HTRANS  = HTRANS_IDLE;
        HWRITE  = 1'b0;
        HWDATA  = '0;
        HREADY  = 1'b1;
        PSEL_en = 1'b0;
        PRDATA  = '0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;

        applyReset();

        $display("[TB] directed transfers");
        applyStimulus(1'b0, 1'b1, 0, 1'b0, 32'h4000_0010, 32'h0000_0000, 32'hCAFE_F00D);
        applyStimulus(1'b1, 1'b1, 2, 1'b0, 32'h4000_0020, 32'h1234_5678, 32'h0000_0000);
        applyIdle(0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 32'h5000_0000, 32'h0000_0000, 32'h1111_1111);
        applyIdle(2);
        applyStimulus(1'b0, 1'b1, 0, 1'b1, 32'h4000_0030, 32'h0000_0000, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b1, 1, 1'b1, 32'h4000_0034, 32'hA5A5_5A5A, 32'h0000_0000);
        applyResetMidAccess();
        applyStimulus(1'b0, 1'b1, 1, 1'b0, 32'h4000_0044, 32'h0000_0000, 32'h0BAD_CAFE);
        applyStimulus(1'b0, 1'b1, TIMEOUT_CYC, 1'b0, 32'h4000_0050, 32'h0, 32'h7777_0001);
        applyStimulus(1'b0, 1'b1, TIMEOUT_CYC - 1, 1'b0, 32'h4000_0054, 32'h0, 32'h7777_0002);
        applyStimulus(1'b1, 1'b1, TIMEOUT_CYC, 1'b0, 32'h4000_0058, 32'h0F0F_F0F0, 32'h0);

        $display("[TB] randomized transfers");
        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 9));
            if (op < 2) begin
                applyIdle(int'($urandom_range(0, 4)));
            end else if (op == 2) begin
                applyStimulus(1'($urandom_range(0, 1)), 1'b0, 0, 1'b0,
                              $urandom, $urandom, $urandom);
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 3)),
                              ($urandom_range(0, 5) == 0), $urandom, $urandom, $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

    // Backstop in case the bench itself stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule : tb_ahb_apb_bridge_fsm

// File: doc/ahb_apb_bridge_fsm.md
Name: ahb_apb_bridge_fsm

Overview:
- Control stage of the AHB-to-APB bridge. Sits directly downstream of the address decoder and consumes its PSEL_en select.
- Accepts single AHB transfers and converts each one into an APB SETUP/ACCESS sequence.
- Stalls AHB with HREADYOUT until the APB completer responds, then returns read data or an error.

Parameters:
- ADDR_W, 32, width of HADDR and PADDR
- DATA_W, 32, width of HWDATA, HRDATA, PWDATA and PRDATA
- TIMEOUT_CYC, 16, ACCESS wait-cycle limit; only used when APB_TIMEOUT_EN is defined

Ports:
- HCLK  in  1  bridge clock
- HRESETn  in  1  synchronous active-low reset, sampled on rising HCLK
- HSEL  in  1  AHB slave select for the bridge
- HADDR  in  ADDR_W  AHB address
- HTRANS  in  2  AHB transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- HWRITE  in  1  1=write
- HWDATA  in  DATA_W  write data, valid in the data phase
- HREADY  in  1  bus-wide ready
- PSEL_en  in  1  APB select from the address decoder
- HREADYOUT  out  1  bridge ready
- HRESP  out  1  0=OKAY, 1=ERROR
- HRDATA  out  DATA_W  registered read data
- PADDR  out  ADDR_W  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB completer ready
- PSLVERR  in  1  APB completer error

Behaviour:
- Reset is synchronous. On the HCLK edge where HRESETn=0:
  - state is set to IDLE
  - HREADYOUT=1, HRESP=0
  - PSEL=0, PENABLE=0, PWRITE=0
  - PADDR=0, PWDATA=0, HRDATA=0
  - Any in-flight APB transfer is dropped immediately, with no completion.
- Accept condition is HSEL & HREADY & HTRANS[1]. It is evaluated only in states IDLE, DONE and ERR2. On accept, HADDR and HWRITE are latched.
- Transfers with HTRANS of IDLE or BUSY, or with HSEL=0, get a zero-wait OKAY response and cause no state change. The exception is DONE and ERR2, which return to IDLE.
- IDLE, DONE or ERR2 on accept:
  - PSEL_en=0 → ERR1 (decode error)
  - PSEL_en=1 and HWRITE=1 → WWAIT
  - PSEL_en=1 and HWRITE=0 → SETUP
- WWAIT: latch HWDATA into PWDATA → SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR and PWRITE driven from the latched values → ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=0: stay in ACCESS.
  - PREADY=1, PSLVERR=0: HRDATA<=PRDATA (reads only) → DONE.
  - PREADY=1, PSLVERR=1: → ERR1.
- DONE: HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0.
- ERR1: HREADYOUT=0, HRESP=1, PSEL=0.
- ERR2: HREADYOUT=1, HRESP=1. This gives the standard two-cycle AHB ERROR response.
- HREADYOUT=0 in WWAIT, SETUP, ACCESS and ERR1; HREADYOUT=1 in IDLE, DONE and ERR2. HRESP=1 only in ERR1 and ERR2.
- Latency, with the address phase at cycle N and PREADY=1 on the first ACCESS cycle:
  - read: HREADYOUT=1 at N+3
  - write: HREADYOUT=1 at N+4
  - each PREADY=0 cycle adds one cycle.
- PADDR, PWRITE and PWDATA stay stable from SETUP through the final ACCESS cycle.
- HRDATA holds its last value otherwise; it is not cleared on writes or errors.
- Back-to-back: a transfer accepted in DONE or ERR2 enters WWAIT, SETUP or ERR1 on the next edge, with no IDLE bubble.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- When defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - If PREADY is still 0 after TIMEOUT_CYC ACCESS cycles, the bridge deasserts PSEL and PENABLE and goes to ERR1. HRDATA is unchanged.
  - PREADY=1 on the same cycle as the limit wins: normal completion.
- When undefined: the bridge waits in ACCESS indefinitely, no counter logic is built, and TIMEOUT_CYC is ignored.

Decomposition:
- Package ahb_apb_pkg holds:
  - the state enum (IDLE, WWAIT, SETUP, ACCESS, DONE, ERR1, ERR2)
  - HTRANS constants
  - HRESP_OKAY and HRESP_ERROR
- One sub-module, apb_timeout_cnt, instantiated only under APB_TIMEOUT_EN. Inputs are clear and count enables; output is an expired flag. Its width is clog2(TIMEOUT_CYC+1).

Test Plan:
- Read, zero-wait: NONSEQ read at HADDR=0x4000_0010, PSEL_en=1, PRDATA=0xCAFE_F00D, PREADY=1 on first ACCESS → SETUP at N+1, ACCESS at N+2, HREADYOUT=1 and HRDATA=0xCAFE_F00D at N+3, HRESP=0.
- Write, 2 wait states: HWDATA=0x1234_5678, PREADY low for 2 ACCESS cycles → PWDATA=0x1234_5678 and PADDR stable throughout, PWRITE=1, HREADYOUT=1 at N+6.
- Decode error: valid NONSEQ with PSEL_en=0 → PSEL never asserted; HRESP=1 with HREADYOUT=0, then HRESP=1 with HREADYOUT=1, then IDLE.
- Slave error: read with PREADY=1, PSLVERR=1 → ERR1, ERR2; HRDATA unchanged from the previous value.
- Reset mid-ACCESS: HRESETn=0 for 1 cycle while PSEL=PENABLE=1 → next edge PSEL=0, PENABLE=0, HREADYOUT=1; the following transfer completes normally.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYC=4): PREADY held 0 → PSEL=0 after the 4th ACCESS cycle, ERROR response. Second run with PREADY=1 on the 4th cycle → OKAY.
